// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers,
// granting bursts of up to BURST_MAX words with a zero-latency req/gnt handshake.
//
// state | meaning
// IDLE  | no owner; pick the next requester starting at rr_ptr
// GRANT | owner holds the port; words move whenever req[owner] and fifo not full
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din_flat,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);
    localparam logic [PTR_W-1:0] MAX_IDX   = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   beat_cnt;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               owner_req;
    logic               owner_last;
    logic               xfer;

    // Explicit modulo so non-power-of-2 NUM_REQ never scans a missing index.
    function automatic logic [PTR_W-1:0] scan_at(input logic [PTR_W-1:0] base,
                                                 input int               offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_valid && req[scan_at(rr_ptr, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_at(rr_ptr, k);
            end
        end
    end

    assign owner_req  = req[owner];
    assign owner_last = last[owner];
    assign xfer       = !rst && (state == GRANT) && owner_req && !fifo_full;

    always_comb begin
        gnt = '0;
        if (xfer) gnt = NUM_REQ'(1) << owner;
    end

    assign fifo_wr_en = xfer;
    assign fifo_din   = (state == GRANT) ? din_flat[owner*DATA_WIDTH +: DATA_WIDTH]
                                         : din_flat[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_idx;
                        rr_ptr   <= (pick_idx == MAX_IDX) ? '0 : pick_idx + 1'b1;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // Cutoff at BURST_MAX keeps one producer from starving the rest.
                        if (owner_last || beat_cnt == LAST_BEAT) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change 1ns after posedge, outputs
// are checked 2ns later, mid-cycle.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int BM = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR-1:0]   last;
    logic [DW-1:0]   din [NR];
    logic [NR*DW-1:0] din_flat;
    logic [NR-1:0]   gnt;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic            busy;
    logic [1:0]      owner;

    int n_cmp  = 0;
    int n_fail = 0;
    int writes;

    always #5 clk = ~clk;

    always_comb begin
        din_flat = '0;
        for (int i = 0; i < NR; i++) din_flat[i*DW +: DW] = din[i];
    end

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .din_flat(din_flat),
        .gnt(gnt), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .busy(busy), .owner(owner)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; last = '0; fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) din[i] = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; last = 4'b1111; fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) din[i] = 64'hDEAD_0000 + 64'(i);
        next_cycle();
        next_cycle();
        #2;
        n_cmp++;
        if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gnt: gnt=%b wr_en=%b, want 0000/0", gnt, fifo_wr_en);
        end
        rst = 1'b0; req = '0;
        next_cycle();
        #2;
        n_cmp++;
        if (busy !== 1'b0 || owner !== 2'd0 || dut.rr_ptr !== 2'd0 || dut.beat_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_regs: busy=%b owner=%0d rr_ptr=%0d beat=%0d, want 0/0/0/0",
                     busy, owner, dut.rr_ptr, dut.beat_cnt);
        end
    endtask

    task automatic test_single_burst();
        logic [DW-1:0] words [3];
        words[0] = 64'hAAAA_0001; words[1] = 64'hBBBB_0002; words[2] = 64'hCCCC_0003;
        apply_reset();
        req = 4'b0100; din[2] = words[0];
        #2;
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL burst_arb_cycle: busy=%b gnt=%b, want 0/0000", busy, gnt);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            din[2] = words[k];
            last   = (k == 2) ? 4'b0100 : 4'b0000;
            #2;
            n_cmp++;
            if (busy !== 1'b1 || owner !== 2'd2 || gnt !== 4'b0100 || fifo_wr_en !== 1'b1 ||
                fifo_din !== words[k]) begin
                n_fail++;
                $display("FAIL burst_beat%0d: busy=%b owner=%0d gnt=%b wr_en=%b din=%h, want 1/2/0100/1/%h",
                         k, busy, owner, gnt, fifo_wr_en, fifo_din, words[k]);
            end
        end
        next_cycle();
        req = '0; last = '0;
        #2;
        n_cmp++;
        if (busy !== 1'b0 || owner !== 2'd2 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL burst_release: busy=%b owner=%0d gnt=%b, want 0/2/0000", busy, owner, gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_owner;
        apply_reset();
        req = 4'b1111; last = 4'b1111;
        for (int i = 0; i < NR; i++) din[i] = 64'h1000 + 64'(i);
        for (int g = 0; g < 6; g++) begin
            exp_owner = 2'(g % NR);
            #2;
            n_cmp++;
            if (busy !== 1'b0 || gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_idle%0d: busy=%b gnt=%b, want 0/0000", g, busy, gnt);
            end
            next_cycle();
            #2;
            n_cmp++;
            if (owner !== exp_owner || gnt !== (4'b0001 << exp_owner) ||
                fifo_din !== 64'h1000 + 64'(exp_owner)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: owner=%0d gnt=%b din=%h, want %0d/%b/%h", g, owner, gnt,
                         fifo_din, exp_owner, 4'b0001 << exp_owner, 64'h1000 + 64'(exp_owner));
            end
            next_cycle();
        end
        req = '0; last = '0;
    endtask

    task automatic test_stall();
        apply_reset();
        writes = 0;
        req = 4'b0010; din[1] = 64'h5100;
        #2;
        next_cycle();
        #2;
        if (fifo_wr_en) writes++;
        n_cmp++;
        if (gnt !== 4'b0010 || fifo_din !== 64'h5100) begin
            n_fail++;
            $display("FAIL stall_first: gnt=%b din=%h, want 0010/%h", gnt, fifo_din, 64'h5100);
        end
        for (int s = 0; s < 5; s++) begin
            next_cycle();
            fifo_full = 1'b1; din[1] = 64'h5101;
            #2;
            if (fifo_wr_en) writes++;
            n_cmp++;
            if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || owner !== 2'd1 || busy !== 1'b1 ||
                dut.beat_cnt !== 3'd1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: gnt=%b wr_en=%b owner=%0d busy=%b beat=%0d, want 0000/0/1/1/1",
                         s, gnt, fifo_wr_en, owner, busy, dut.beat_cnt);
            end
        end
        for (int k = 1; k < 3; k++) begin
            next_cycle();
            fifo_full = 1'b0; din[1] = 64'h5100 + 64'(k);
            last = (k == 2) ? 4'b0010 : 4'b0000;
            #2;
            if (fifo_wr_en) writes++;
            n_cmp++;
            if (gnt !== 4'b0010 || fifo_din !== 64'h5100 + 64'(k)) begin
                n_fail++;
                $display("FAIL stall_resume%0d: gnt=%b din=%h, want 0010/%h", k, gnt, fifo_din,
                         64'h5100 + 64'(k));
            end
        end
        next_cycle();
        req = '0; last = '0;
        #2;
        if (fifo_wr_en) writes++;
        n_cmp++;
        if (writes !== 3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_total: writes=%0d busy=%b, want 3/0", writes, busy);
        end
    endtask

    task automatic test_burst_cutoff();
        apply_reset();
        req = 4'b0011; last = 4'b0010; din[1] = 64'h2000;
        #2;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            din[0] = 64'h100 + 64'(k);
            #2;
            n_cmp++;
            if (owner !== 2'd0 || gnt !== 4'b0001 || fifo_din !== 64'h100 + 64'(k)) begin
                n_fail++;
                $display("FAIL cut_first%0d: owner=%0d gnt=%b din=%h, want 0/0001/%h", k, owner, gnt,
                         fifo_din, 64'h100 + 64'(k));
            end
        end
        next_cycle();
        din[0] = 64'h104;
        #2;
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL cut_release: busy=%b gnt=%b, want 0/0000", busy, gnt);
        end
        next_cycle();
        #2;
        n_cmp++;
        if (owner !== 2'd1 || gnt !== 4'b0010 || fifo_din !== 64'h2000) begin
            n_fail++;
            $display("FAIL cut_other: owner=%0d gnt=%b din=%h, want 1/0010/2000", owner, gnt, fifo_din);
        end
        next_cycle();
        #2;
        for (int k = 4; k < 6; k++) begin
            next_cycle();
            din[0] = 64'h100 + 64'(k);
            last   = (k == 5) ? 4'b0011 : 4'b0010;
            #2;
            n_cmp++;
            if (owner !== 2'd0 || gnt !== 4'b0001 || fifo_din !== 64'h100 + 64'(k)) begin
                n_fail++;
                $display("FAIL cut_rest%0d: owner=%0d gnt=%b din=%h, want 0/0001/%h", k, owner, gnt,
                         fifo_din, 64'h100 + 64'(k));
            end
        end
        next_cycle();
        req = '0; last = '0;
        #2;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cut_done: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_abort_wrap();
        apply_reset();
        req = 4'b1000; din[3] = 64'h3300; din[1] = 64'h1100;
        #2;
        next_cycle();
        req = 4'b1010;
        #2;
        n_cmp++;
        if (owner !== 2'd3 || gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL abort_grant: owner=%0d gnt=%b, want 3/1000", owner, gnt);
        end
        next_cycle();
        req = 4'b0010;
        #2;
        n_cmp++;
        if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_cycle: gnt=%b wr_en=%b busy=%b, want 0000/0/1", gnt, fifo_wr_en, busy);
        end
        next_cycle();
        #2;
        n_cmp++;
        if (busy !== 1'b0 || dut.rr_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_release: busy=%b rr_ptr=%0d, want 0/0", busy, dut.rr_ptr);
        end
        next_cycle();
        last = 4'b0010;
        #2;
        n_cmp++;
        if (owner !== 2'd1 || gnt !== 4'b0010 || fifo_din !== 64'h1100) begin
            n_fail++;
            $display("FAIL abort_wrap: owner=%0d gnt=%b din=%h, want 1/0010/1100", owner, gnt, fifo_din);
        end
        next_cycle();
        req = '0; last = '0;
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        req = 4'b1001; din[0] = 64'h7700;
        #2;
        next_cycle();
        req = 4'b0001;
        #2;
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_beat1: gnt=%b, want 0001", gnt);
        end
        next_cycle();
        rst = 1'b1; din[0] = 64'h7701;
        #2;
        n_cmp++;
        if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_cycle: gnt=%b wr_en=%b, want 0000/0", gnt, fifo_wr_en);
        end
        next_cycle();
        rst = 1'b0;
        #2;
        n_cmp++;
        if (busy !== 1'b0 || dut.rr_ptr !== 2'd0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_after: busy=%b rr_ptr=%0d gnt=%b, want 0/0/0000", busy, dut.rr_ptr, gnt);
        end
        next_cycle();
        #2;
        n_cmp++;
        if (busy !== 1'b1 || owner !== 2'd0 || gnt !== 4'b0001 || fifo_din !== 64'h7701) begin
            n_fail++;
            $display("FAIL midrst_regrant: busy=%b owner=%0d gnt=%b din=%h, want 1/0/0001/7701",
                     busy, owner, gnt, fifo_din);
        end
        next_cycle();
        req = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; last = '0; fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) din[i] = '0;
        #1;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_stall();
        test_burst_cutoff();
        test_abort_wrap();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
